acc_cpu_param: RTL and testbench

//  Parametrised accumulator CPU: DW-bit data, 2^AW-entry code and data memories, 8-opcode ISA.

---
 rtl/acc_cpu_param_if.sv | 25 ++
 rtl/acc_cpu_param.sv | 260 ++++++++++++++++++++++++++
 tb/tb_acc_cpu_param.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_param_if.sv
// Command channel of the accumulator CPU.
// The master drives a 2-bit command and a DW-bit argument under valid/ready.
// A command transfers on a posedge where cmd_valid and cmd_ready are both high.
interface acc_cpu_param_if #(
   parameter int DW = 4
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd;
   logic [DW-1:0] cmd_arg;

   modport master (
      output cmd_valid,
      output cmd,
      output cmd_arg,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd,
      input  cmd_arg,
      output cmd_ready
   );
endinterface

// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU with an 8-opcode ISA.
// Code memory holds 3-bit opcodes and data memory holds DW-bit operands, both
// indexed by pc, so each instruction reads its opcode and operand from the
// same address in the same cycle.
// A run FSM (IDLE / EXEC / HALTED) executes one instruction per cycle. It
// supports an optional step budget, HALT, and an external stop.
// Optional feature macro: ACC_CPU_OUT_EN enables the OUT opcode. When it is
// undefined, opcode 6 is a NOP and out_valid/out_data stay at 0.
module acc_cpu_param #(
   parameter int DW = 4,
   parameter int AW = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   acc_cpu_param_if.slave    cmd_if,
   input  logic              stop,
   output logic [AW-1:0]     pc,
   output logic [DW-1:0]     acc,
   output logic              carry,
   output logic              halted,
   output logic              out_valid,
   output logic [DW-1:0]     out_data
);

   localparam int DEPTH = 1 << AW;

   localparam logic [1:0] CMD_SETPC    = 2'd0;
   localparam logic [1:0] CMD_LOADCODE = 2'd1;
   localparam logic [1:0] CMD_LOADDATA = 2'd2;
   localparam logic [1:0] CMD_RUN      = 2'd3;

   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_STORE = 3'd1;
   localparam logic [2:0] OP_ADD   = 3'd2;
   localparam logic [2:0] OP_BZ    = 3'd3;
   localparam logic [2:0] OP_SUB   = 3'd4;
   localparam logic [2:0] OP_JMP   = 3'd5;
   localparam logic [2:0] OP_OUT   = 3'd6;
   localparam logic [2:0] OP_HALT  = 3'd7;

   localparam logic [AW-1:0] PC_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [DW-1:0] STEP_ONE = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXEC   = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [AW-1:0]   pc_r;
   logic [AW-1:0]   pc_nxt_s;
   logic [DW-1:0]   acc_r;
   logic [DW-1:0]   acc_nxt_s;
   logic            carry_r;
   logic            carry_nxt_s;
   logic [DW-1:0]   steps_r;
   logic [DW-1:0]   steps_nxt_s;
   logic            out_valid_r;
   logic            out_valid_nxt_s;
   logic [DW-1:0]   out_data_r;
   logic [DW-1:0]   out_data_nxt_s;
   logic            halted_r;
   logic            cmd_ready_r;

   logic [2:0]      code_mem_r [DEPTH];
   logic [DW-1:0]   data_mem_r [DEPTH];

   logic            code_we_s;
   logic            data_we_s;
   logic [AW-1:0]   data_waddr_s;
   logic [DW-1:0]   data_wdata_s;

   logic [2:0]      op_s;
   logic [DW-1:0]   opnd_s;
   logic [AW-1:0]   npc_s;
   logic [DW:0]     sum_s;
   logic [DW:0]     diff_s;
   logic            cmd_fire_s;

   // The operand is read combinationally, so a STORE becomes visible only
   // from the following cycle. Subtraction borrow lands in diff_s[DW].
   assign op_s       = code_mem_r[pc_r];
   assign opnd_s     = data_mem_r[pc_r];
   assign npc_s      = pc_r + PC_ONE;
   assign sum_s      = {1'b0, acc_r} + {1'b0, opnd_s};
   assign diff_s     = {1'b0, acc_r} - {1'b0, opnd_s};
   assign cmd_fire_s = cmd_if.cmd_valid & cmd_ready_r;

   assign cmd_if.cmd_ready = cmd_ready_r;
   assign pc               = pc_r;
   assign acc              = acc_r;
   assign carry            = carry_r;
   assign halted           = halted_r;
   assign out_valid        = out_valid_r;
   assign out_data         = out_data_r;

   // Next-state logic: command handling outside EXEC, one instruction per cycle in EXEC
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      acc_nxt_s       = acc_r;
      carry_nxt_s     = carry_r;
      steps_nxt_s     = steps_r;
      out_valid_nxt_s = 1'b0;
      out_data_nxt_s  = out_data_r;
      code_we_s       = 1'b0;
      data_we_s       = 1'b0;
      data_waddr_s    = pc_r;
      data_wdata_s    = cmd_if.cmd_arg;

      case (state_r)
         ST_IDLE, ST_HALTED: begin
            if (cmd_fire_s) begin
               case (cmd_if.cmd)
                  CMD_SETPC: begin
                     pc_nxt_s    = cmd_if.cmd_arg[AW-1:0];
                     acc_nxt_s   = '0;
                     carry_nxt_s = 1'b0;
                     state_nxt_s = ST_IDLE;
                  end
                  CMD_LOADCODE: begin
                     code_we_s = 1'b1;
                     pc_nxt_s  = npc_s;
                  end
                  CMD_LOADDATA: begin
                     data_we_s = 1'b1;
                     pc_nxt_s  = npc_s;
                  end
                  CMD_RUN: begin
                     // RUN is accepted in HALTED but changes nothing there
                     if (state_r == ST_IDLE) begin
                        steps_nxt_s = cmd_if.cmd_arg;
                        state_nxt_s = ST_EXEC;
                     end else begin
                        steps_nxt_s = steps_r;
                     end
                  end
                  default: begin
                     state_nxt_s = state_r;
                  end
               endcase
            end else begin
               state_nxt_s = state_r;
            end
         end

         ST_EXEC: begin
            if (stop) begin
               // An abort takes priority: nothing executes this cycle
               state_nxt_s = ST_IDLE;
               steps_nxt_s = '0;
            end else begin
               case (op_s)
                  OP_LOAD: begin
                     acc_nxt_s = opnd_s;
                     pc_nxt_s  = npc_s;
                  end
                  OP_STORE: begin
                     data_we_s    = 1'b1;
                     data_waddr_s = opnd_s[AW-1:0];
                     data_wdata_s = acc_r;
                     pc_nxt_s     = npc_s;
                  end
                  OP_ADD: begin
                     {carry_nxt_s, acc_nxt_s} = sum_s;
                     pc_nxt_s                 = npc_s;
                  end
                  OP_BZ: begin
                     if (acc_r == '0) begin
                        pc_nxt_s = opnd_s[AW-1:0];
                     end else begin
                        pc_nxt_s = npc_s;
                     end
                  end
                  OP_SUB: begin
                     {carry_nxt_s, acc_nxt_s} = diff_s;
                     pc_nxt_s                 = npc_s;
                  end
                  OP_JMP: begin
                     pc_nxt_s = opnd_s[AW-1:0];
                  end
                  OP_OUT: begin
`ifdef ACC_CPU_OUT_EN
                     out_valid_nxt_s = 1'b1;
                     out_data_nxt_s  = acc_r;
`else
                     out_valid_nxt_s = 1'b0;
`endif
                     pc_nxt_s = npc_s;
                  end
                  OP_HALT: begin
                     pc_nxt_s = pc_r;
                  end
                  default: begin
                     pc_nxt_s = npc_s;
                  end
               endcase

               // HALT overrides any pending step budget
               if (op_s == OP_HALT) begin
                  state_nxt_s = ST_HALTED;
                  steps_nxt_s = '0;
               end else if (steps_r != '0) begin
                  steps_nxt_s = steps_r - STEP_ONE;
                  if (steps_r == STEP_ONE) begin
                     state_nxt_s = ST_IDLE;
                  end else begin
                     state_nxt_s = ST_EXEC;
                  end
               end else begin
                  steps_nxt_s = '0;
               end
            end
         end

         default: begin
            state_nxt_s = ST_IDLE;
            steps_nxt_s = '0;
         end
      endcase
   end

   // State, architectural registers and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pc_r        <= '0;
         acc_r       <= '0;
         carry_r     <= 1'b0;
         steps_r     <= '0;
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         halted_r    <= 1'b0;
         cmd_ready_r <= 1'b1;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         acc_r       <= acc_nxt_s;
         carry_r     <= carry_nxt_s;
         steps_r     <= steps_nxt_s;
         out_valid_r <= out_valid_nxt_s;
         out_data_r  <= out_data_nxt_s;
         halted_r    <= (state_nxt_s == ST_HALTED);
         cmd_ready_r <= (state_nxt_s != ST_EXEC);
      end
   end

   // Memory write ports; contents survive reset but no write lands while it is asserted
   always_ff @(posedge clk) begin
      if (rst_n && code_we_s) begin
         code_mem_r[pc_r] <= cmd_if.cmd_arg[2:0];
      end
      if (rst_n && data_we_s) begin
         data_mem_r[data_waddr_s] <= data_wdata_s;
      end
   end

endmodule

// File: tb/tb_acc_cpu_param.sv
// Self-checking bench for acc_cpu_param.
// The bench keeps a cycle-level reference model of the programmer-visible
// machine in plain integers and arrays. The model covers the mode, pc, acc,
// carry, step budget and both memories. The bench compares every DUT output
// against the model after each clock, and also checks directed scenarios
// against hand-derived constants.
module tb_acc_cpu_param;
   localparam int DW    = 4;
   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;
   localparam int DMOD  = 1 << DW;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_HALTED = 2;

   logic          clk;
   logic          rst_n;
   logic          stop;
   logic [AW-1:0] pc;
   logic [DW-1:0] acc;
   logic          carry;
   logic          halted;
   logic          out_valid;
   logic [DW-1:0] out_data;

   acc_cpu_param_if #(.DW(DW)) cmd_if ();

   acc_cpu_param #(.DW(DW), .AW(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_if    (cmd_if.slave),
      .stop      (stop),
      .pc        (pc),
      .acc       (acc),
      .carry     (carry),
      .halted    (halted),
      .out_valid (out_valid),
      .out_data  (out_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   int m_pc, m_acc, m_carry, m_mode, m_steps, m_outv, m_outd;
   int m_code [DEPTH];
   int m_data [DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance the model by one clock using the inputs present at that edge
   task automatic model_step();
      int op, a, np, r;
      m_outv = 0;
      if (!rst_n) begin
         m_pc = 0; m_acc = 0; m_carry = 0; m_mode = M_IDLE; m_steps = 0; m_outd = 0;
      end else if (m_mode != M_RUN) begin
         if (cmd_if.cmd_valid) begin
            case (int'(cmd_if.cmd))
               0: begin
                  m_pc = int'(cmd_if.cmd_arg) % DEPTH; m_acc = 0; m_carry = 0; m_mode = M_IDLE;
               end
               1: begin
                  m_code[m_pc] = int'(cmd_if.cmd_arg) % 8; m_pc = (m_pc + 1) % DEPTH;
               end
               2: begin
                  m_data[m_pc] = int'(cmd_if.cmd_arg); m_pc = (m_pc + 1) % DEPTH;
               end
               default: begin
                  if (m_mode == M_IDLE) begin
                     m_steps = int'(cmd_if.cmd_arg); m_mode = M_RUN;
                  end
               end
            endcase
         end
      end else if (stop) begin
         m_mode = M_IDLE; m_steps = 0;
      end else begin
         op = m_code[m_pc];
         a  = m_data[m_pc];
         np = (m_pc + 1) % DEPTH;
         case (op)
            0: begin m_acc = a; m_pc = np; end
            1: begin m_data[a % DEPTH] = m_acc; m_pc = np; end
            2: begin r = m_acc + a; m_acc = r % DMOD; m_carry = (r >= DMOD) ? 1 : 0; m_pc = np; end
            3: m_pc = (m_acc == 0) ? a % DEPTH : np;
            4: begin r = m_acc - a; m_carry = (r < 0) ? 1 : 0; m_acc = (r + DMOD) % DMOD; m_pc = np; end
            5: m_pc = a % DEPTH;
            6: begin
`ifdef ACC_CPU_OUT_EN
               m_outv = 1; m_outd = m_acc;
`endif
               m_pc = np;
            end
            default: begin m_mode = M_HALTED; m_steps = 0; end
         endcase
         if (op != 7 && m_steps != 0) begin
            m_steps--;
            if (m_steps == 0) m_mode = M_IDLE;
         end
      end
   endtask

   task automatic compare_all();
      check("pc", 32'(pc), 32'(m_pc));
      check("acc", 32'(acc), 32'(m_acc));
      check("carry", 32'(carry), 32'(m_carry));
      check("halted", 32'(halted), (m_mode == M_HALTED) ? 32'd1 : 32'd0);
      check("cmd_ready", 32'(cmd_if.cmd_ready), (m_mode != M_RUN) ? 32'd1 : 32'd0);
      check("out_valid", 32'(out_valid), 32'(m_outv));
      check("out_data", 32'(out_data), 32'(m_outd));
   endtask

   // One clock: the model consumes the same inputs the DUT sampled, then outputs are compared
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic do_cmd(input int c, input int arg);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd       = 2'(c);
      cmd_if.cmd_arg   = DW'(arg);
      tick();
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic run_until_done(input int budget);
      int n = 0;
      while (m_mode == M_RUN && n < budget) begin
         tick();
         n++;
      end
      if (m_mode == M_RUN) check("run_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int cnt;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd       = 2'd0;
      cmd_if.cmd_arg   = '0;
      stop             = 1'b0;
      rst_n            = 1'b0;
      m_outd = 0;
      for (int i = 0; i < DEPTH; i++) begin m_code[i] = 0; m_data[i] = 0; end
      #2;
      tick();
      tick();
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      // Fill both memories so no later read sees uninitialised contents
      do_cmd(0, 0);
      for (int i = 0; i < DEPTH; i++) do_cmd(1, 0);
      do_cmd(0, 0);
      for (int i = 0; i < DEPTH; i++) do_cmd(2, 0);

      // Program: LOAD, ADD, STORE, HALT -> acc = 5 + 3, data[6] = 8
      do_cmd(0, 0);
      do_cmd(1, 0); do_cmd(1, 2); do_cmd(1, 1); do_cmd(1, 7);
      do_cmd(0, 0);
      do_cmd(2, 5); do_cmd(2, 3); do_cmd(2, 6);
      do_cmd(0, 0);
      do_cmd(3, 0);
      cnt = 0;
      while (halted !== 1'b1 && cnt < 20) begin tick(); cnt++; end
      check("t1_cycles", 32'(cnt), 32'd4);
      check("t1_acc", 32'(acc), 32'd8);
      check("t1_pc", 32'(pc), 32'd3);
      check("t1_halted", 32'(halted), 32'd1);
      do_cmd(3, 5);
      check("t1_run_in_halted", 32'(halted), 32'd1);
      // Read data[6] back through a LOAD at address 6
      do_cmd(0, 6); do_cmd(1, 0); do_cmd(0, 6); do_cmd(3, 1);
      run_until_done(5);
      check("t1_store", 32'(acc), 32'd8);

      // Step budget of 2 stops before the STORE
      do_cmd(0, 0);
      do_cmd(3, 2);
      tick();
      check("t3_ready_mid", 32'(cmd_if.cmd_ready), 32'd0);
      tick();
      check("t3_pc", 32'(pc), 32'd2);
      check("t3_acc", 32'(acc), 32'd8);
      check("t3_ready", 32'(cmd_if.cmd_ready), 32'd1);

      // Carry / borrow: LOAD 9, ADD 9, SUB 3, SUB 5
      do_cmd(0, 0);
      do_cmd(1, 0); do_cmd(1, 2); do_cmd(1, 4); do_cmd(1, 4);
      do_cmd(0, 0);
      do_cmd(2, 9); do_cmd(2, 9); do_cmd(2, 3); do_cmd(2, 5);
      do_cmd(0, 0);
      do_cmd(3, 2); run_until_done(5);
      check("t2_add_acc", 32'(acc), 32'd2);
      check("t2_add_c", 32'(carry), 32'd1);
      do_cmd(3, 1); run_until_done(5);
      check("t2_sub_acc", 32'(acc), 32'd15);
      check("t2_sub_c", 32'(carry), 32'd1);
      do_cmd(3, 1); run_until_done(5);
      check("t2_sub2_acc", 32'(acc), 32'd10);
      check("t2_sub2_c", 32'(carry), 32'd0);

      // Endless JMP 0 loop aborted by stop
      do_cmd(0, 0); do_cmd(1, 5); do_cmd(0, 0); do_cmd(2, 0); do_cmd(0, 0);
      do_cmd(3, 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_busy", 32'(cmd_if.cmd_ready), 32'd0);
      end
      stop = 1'b1; tick(); stop = 1'b0;
      check("t4_pc", 32'(pc), 32'd0);
      check("t4_ready", 32'(cmd_if.cmd_ready), 32'd1);
      check("t4_halted", 32'(halted), 32'd0);

      // OUT at pc 4 with acc 7
      do_cmd(0, 3); do_cmd(1, 0); do_cmd(1, 6);
      do_cmd(0, 3); do_cmd(2, 7);
      do_cmd(0, 3); do_cmd(3, 2);
      tick(); tick();
`ifdef ACC_CPU_OUT_EN
      check("t5_valid", 32'(out_valid), 32'd1);
      check("t5_data", 32'(out_data), 32'd7);
`else
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_data", 32'(out_data), 32'd0);
`endif
      check("t5_pc", 32'(pc), 32'd5);
      tick();
      check("t5_pulse", 32'(out_valid), 32'd0);

      // Reset mid-EXEC, then in HALTED
      do_cmd(0, 0); do_cmd(3, 0);
      tick(); tick(); tick();
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t6_exec_pc", 32'(pc), 32'd0);
      check("t6_exec_ready", 32'(cmd_if.cmd_ready), 32'd1);
      do_cmd(0, 7); do_cmd(1, 7); do_cmd(0, 7); do_cmd(3, 0);
      run_until_done(5);
      check("t6_halt_pre", 32'(halted), 32'd1);
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check("t6_halt_pc", 32'(pc), 32'd0);
      check("t6_halt_acc", 32'(acc), 32'd0);
      check("t6_halted", 32'(halted), 32'd0);
      check("t6_carry", 32'(carry), 32'd0);
      do_cmd(0, 6); do_cmd(1, 0); do_cmd(0, 6); do_cmd(3, 1);
      run_until_done(5);
      check("t6_data_kept", 32'(acc), 32'd8);

      // Randomised programs and commands, every cycle checked against the model
      for (int it = 0; it < 400; it++) begin
         case ($urandom_range(0, 6))
            0, 1: do_cmd(1, int'($urandom_range(0, 7)));
            2:    do_cmd(2, int'($urandom_range(0, DMOD - 1)));
            3:    do_cmd(0, int'($urandom_range(0, DMOD - 1)));
            4: begin
               do_cmd(3, ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 6)));
               cnt = 0;
               while (m_mode == M_RUN && cnt < 80) begin
                  stop  = ($urandom_range(0, 31) == 0) || (cnt > 60);
                  rst_n = ($urandom_range(0, 63) != 0);
                  cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
                  cmd_if.cmd       = 2'($urandom_range(0, 3));
                  cmd_if.cmd_arg   = DW'($urandom_range(0, DMOD - 1));
                  tick();
                  cnt++;
               end
               if (m_mode == M_RUN) check("rand_timeout", 32'd1, 32'd0);
               stop = 1'b0; rst_n = 1'b1; cmd_if.cmd_valid = 1'b0;
            end
            default: begin
               stop = ($urandom_range(0, 1) == 0);
               tick();
               stop = 1'b0;
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
